// File: rtl/fft_pkg.sv
// Shared types for the FFT peak sequencer: controller state encoding and the packed
// complex word layout used on the fft_top data ports.
package fft_pkg;

    localparam int CPLX_BW = 16;

    typedef struct packed {
        logic signed [CPLX_BW-1:0] re;
        logic signed [CPLX_BW-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_REPORT
    } state_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Registered alpha-max-beta-min magnitude: max(|re|,|im|) + min(|re|,|im|)/2,
// saturated to the unsigned BIT_WIDTH+1 output range.
module fft_mag_approx #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] re,
    input  logic [BIT_WIDTH-1:0] im,
    output logic [BIT_WIDTH:0]   mag
);

    logic [BIT_WIDTH:0]   re_x;
    logic [BIT_WIDTH:0]   im_x;
    logic [BIT_WIDTH:0]   abs_re;
    logic [BIT_WIDTH:0]   abs_im;
    logic [BIT_WIDTH:0]   hi;
    logic [BIT_WIDTH:0]   lo;
    logic [BIT_WIDTH+1:0] sum;

    // Sign-extend by one bit first so that the most negative input has a representable magnitude.
    always_comb begin
        re_x   = {re[BIT_WIDTH-1], re};
        im_x   = {im[BIT_WIDTH-1], im};
        abs_re = re_x[BIT_WIDTH] ? (~re_x + 1'b1) : re_x;
        abs_im = im_x[BIT_WIDTH] ? (~im_x + 1'b1) : im_x;
        hi     = (abs_re > abs_im) ? abs_re : abs_im;
        lo     = (abs_re > abs_im) ? abs_im : abs_re;
        sum    = {1'b0, hi} + ({1'b0, lo} >> 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag <= '0;
        end else begin
            mag <= sum[BIT_WIDTH+1] ? '1 : sum[BIT_WIDTH:0];
        end
    end

endmodule

// File: rtl/fft_peak_sequencer.sv
// Frame sequencer around fft_top: loads N samples, runs the transform, then scans
// bins 0..N/2-1 for the strongest approximate magnitude and reports it.
//
// state  | meaning
// IDLE   | waiting for arm
// FILL   | accepting samples and writing them into fft_top RAM
// START  | requesting the transform
// WAIT   | waiting for fft_top done
// READ   | stepping the read address over bins 0..N/2-1
// DRAIN  | letting the read/magnitude/compare pipeline empty
// REPORT | publishing the peak, then refill (continuous) or idle
module fft_peak_sequencer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int M         = 9,
    parameter int N         = 512,
    parameter int RD_LAT    = 1,
    parameter int MIN_BIN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   continuous,
    input  logic                   sample_valid,
    input  logic [BIT_WIDTH-1:0]   sample_in,
    output logic                   sample_ready,
    output logic                   fft_load,
    output logic                   fft_start,
    output logic [M-1:0]           fft_adr,
    output logic [2*BIT_WIDTH-1:0] fft_wdata,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] fft_out,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [BIT_WIDTH:0]     peak_mag
);

    localparam logic [M-1:0] LAST_IDX   = M'(N - 1);
    localparam logic [M-1:0] LAST_RD    = M'(N / 2 - 1);
    localparam logic [M-1:0] MIN_IDX    = M'(MIN_BIN);
    localparam logic [2:0]   DRAIN_LOAD = 3'(RD_LAT + 1);

    state_t               state;
    state_t               state_nx;
    logic [M-1:0]         count;
    logic [2:0]           drain_cnt;
    logic                 accept;
    logic                 rd_active;
    logic [BIT_WIDTH-1:0] wdata_hi;
    logic [M-1:0]         tag_pipe [RD_LAT];
    logic [RD_LAT-1:0]    vld_pipe;
    logic [M-1:0]         mag_bin;
    logic                 mag_vld;
    logic [BIT_WIDTH:0]   mag;
    logic [BIT_WIDTH:0]   run_max;
    logic [M-1:0]         run_bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (arm) state_nx = S_FILL;
            S_FILL:   if (accept && count == LAST_IDX) state_nx = S_START;
            S_START:  state_nx = S_WAIT;
            S_WAIT:   if (fft_done) state_nx = S_READ;
            S_READ:   if (fft_adr == LAST_RD) state_nx = S_DRAIN;
            S_DRAIN:  if (drain_cnt == 3'd0) state_nx = S_REPORT;
            S_REPORT: state_nx = continuous ? S_FILL : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (state == S_FILL);
        busy         = (state != S_IDLE);
        rd_active    = (state == S_READ);
    end

    assign accept    = sample_ready & sample_valid;
    assign fft_wdata = {wdata_hi, {BIT_WIDTH{1'b0}}};

    // fft_start is registered so the pulse never overlaps the final sample's load write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fft_load   <= 1'b0;
            fft_start  <= 1'b0;
            fft_adr    <= '0;
            wdata_hi   <= '0;
            count      <= '0;
            drain_cnt  <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            fft_load   <= accept;
            fft_start  <= (state == S_START);
            peak_valid <= (state == S_REPORT);
            case (state)
                S_IDLE: count <= '0;
                S_FILL: begin
                    if (accept) begin
                        fft_adr  <= count;
                        wdata_hi <= sample_in;
                        count    <= count + 1'b1;
                    end
                end
                S_WAIT:  if (fft_done) fft_adr <= '0;
                S_READ: begin
                    fft_adr <= fft_adr + 1'b1;
                    if (fft_adr == LAST_RD) drain_cnt <= DRAIN_LOAD;
                end
                S_DRAIN: if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 1'b1;
                S_REPORT: begin
                    peak_bin <= run_bin;
                    peak_mag <= run_max;
                    count    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Bin index and valid ride alongside the RAM read so they line up with fft_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
            vld_pipe <= '0;
            mag_bin  <= '0;
            mag_vld  <= 1'b0;
        end else begin
            tag_pipe[0] <= fft_adr;
            vld_pipe[0] <= rd_active;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
            mag_bin <= tag_pipe[RD_LAT-1];
            mag_vld <= vld_pipe[RD_LAT-1];
        end
    end

    fft_mag_approx #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_mag (
        .clk  (clk),
        .reset(reset),
        .re   (fft_out[2*BIT_WIDTH-1:BIT_WIDTH]),
        .im   (fft_out[BIT_WIDTH-1:0]),
        .mag  (mag)
    );

    // Strict greater-than keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_max <= '0;
            run_bin <= '0;
        end else if (state == S_WAIT && fft_done) begin
            run_max <= '0;
            run_bin <= MIN_IDX;
        end else if (mag_vld && mag_bin >= MIN_IDX && mag > run_max) begin
            run_max <= mag;
            run_bin <= mag_bin;
        end
    end

endmodule

// File: doc/fft_peak_sequencer.md
Name: fft_peak_sequencer

Overview:
- Frame-level controller that sits between the audio sample stream and fft_top.
- Collects N real samples and writes them into fft_top's RAM through the load port, then pulses start and waits for done.
- Reads back bins 0..N/2-1 and computes an approximate magnitude for each.
- Reports the strongest bin for the tuner's pitch logic. Runs single-shot or continuously, frame after frame.

Parameters:
- BIT_WIDTH, 16, width of a real/imag component; samples are signed BIT_WIDTH.
- M, 9, log2 of the frame length.
- N, 512, frame length; must equal 2**M.
- RD_LAT, 1, cycles from fft_adr presented to fft_out valid (range 1..3).
- MIN_BIN, 1, lowest bin considered in the peak search; bins below it are ignored (DC rejection).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- arm  in  1  one-cycle request to capture a frame while IDLE.
- continuous  in  1  1 = re-enter FILL after every REPORT; sampled only in REPORT.
- sample_valid  in  1  sample_in valid this cycle.
- sample_in  in  BIT_WIDTH  signed real sample.
- sample_ready  out  1  high only in FILL; a sample is accepted when valid&&ready.
- fft_load  out  1  to fft_top load.
- fft_start  out  1  to fft_top start; one-cycle pulse.
- fft_adr  out  M  to fft_top rd_adr; load address in FILL, read address in READ.
- fft_wdata  out  2*BIT_WIDTH  to fft_top rd; {sample, BIT_WIDTH'0} (real upper half, imag lower half).
- fft_done  in  1  from fft_top done.
- fft_out  in  2*BIT_WIDTH  from fft_top wd; {re, im}, both signed.
- busy  out  1  high in every state except IDLE.
- peak_valid  out  1  one-cycle pulse when peak_bin/peak_mag are updated.
- peak_bin  out  M  index of the strongest bin of the last frame.
- peak_mag  out  BIT_WIDTH+1  magnitude of that bin, unsigned.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including peak_bin, peak_mag and fft_wdata; counters cleared. Reset mid-frame discards the frame; fft_top is not notified.
- States: IDLE, FILL, START, WAIT, READ, DRAIN, REPORT.
- IDLE -> FILL on arm=1. arm in any other state is ignored.
- FILL:
  - sample_ready=1. Each accepted sample registers fft_load=1, fft_adr=count and fft_wdata={sample_in,0} on the next cycle.
  - fft_load is 0 in cycles with no accept; count does not advance and nothing is dropped.
  - The accept with count=N-1 moves to START. Samples presented while ready=0 are not accepted; upstream must hold them.
- START: fft_start=1 for exactly one cycle, fft_load=0 -> WAIT.
- WAIT: fft_done is sampled here only. The first cycle fft_done=1 -> READ. A done that was already high on entry counts.
- READ:
  - fft_adr steps 0..N/2-1, one address per cycle, N/2 cycles -> DRAIN.
  - The pipeline tags each address with its bin index, delayed RD_LAT cycles to align with fft_out.
- Magnitude stage (1 register):
  - a=|re|, b=|im| computed at BIT_WIDTH+1 bits, so -2^(BW-1) does not overflow.
  - mag = max(a,b) + (min(a,b)>>1), saturated to 2^(BIT_WIDTH+1)-1.
- Compare stage (1 register):
  - For bin >= MIN_BIN, replace the running peak if mag > running max (strict). On ties the lowest bin wins.
  - Running max is cleared to 0 and running bin to MIN_BIN at READ entry. An all-zero frame reports bin MIN_BIN, mag 0.
- DRAIN: waits RD_LAT+2 cycles for the pipeline to empty -> REPORT.
- REPORT:
  - For one cycle: peak_bin/peak_mag are loaded and peak_valid=1.
  - Next state is FILL if continuous=1, else IDLE. Outputs hold until the next REPORT.
- Latency: peak_valid asserts exactly N/2+RD_LAT+4 cycles after the cycle fft_done is first seen high in WAIT.
- fft_done asserted outside WAIT has no effect.

Decomposition:
- Package fft_pkg: state enum typedef, and a packed complex struct {signed re; signed im} sized by BIT_WIDTH.
- Sub-module fft_mag_approx: registered |re|,|im| to alpha-max-beta-min magnitude with saturation. It is reused by the display path later.

Test Plan:
- Bench setup: N=16, M=4, RD_LAT=1. A behavioural fft_top stub raises done 20 cycles after start and serves a preloaded bin memory.
- Reset: drive reset=0 mid-FILL (count=7) -> all outputs 0 immediately. After release with no arm, busy=0 and no fft_load for 50 cycles.
- Load: arm, then 16 samples 0x0001..0x0010 with valid toggling every other cycle -> stub RAM holds {0x000k,0x0000} at address k-1, and exactly one fft_start pulse follows.
- Peak: stub bins 0=(0x7FFF,0), 3=(0x0100,-0x0200), 5=(-0x0400,0x0100), rest 0 -> peak_bin=5, peak_mag=0x0480. DC is ignored. peak_valid fires N/2+RD_LAT+4=13 cycles after done.
- Tie/overflow: bins 2 and 6 both (-0x8000,-0x8000) -> peak_bin=2, peak_mag=0xC000 with no wrap.
- Continuous: continuous=1 over 3 frames with distinct peaks (4, 7, 1) -> three peak_valid pulses in order. Dropping continuous during frame 3 -> IDLE after its REPORT.
- Done early: stub holds done=1 before start and through START -> WAIT exits on its first cycle, and no READ occurs during FILL.
